// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_load_ctrl: shares the imem port between IF fetch and a byte loader.
// Revision: 1.0
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              load_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_stall,
  output logic              pc_restart,
  output logic              load_busy,
  output logic              load_ovf
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    LO      = 3'd2,
    HI      = 3'd3,
    WRITE   = 3'd4,
    RESTART = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        lo_q, lo_d;
  logic              last_q, last_d;
  logic              full_q, full_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              stall_q, stall_d;
  logic              restart_q, restart_d;
  logic              busy_q, busy_d;
  logic              accept;

  assign accept = load_valid & ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lo_d    = lo_q;
    last_d  = last_q;
    full_d  = full_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        if (load_req) state_d = DRAIN;
      end
      DRAIN: begin
        ptr_d   = '0;
        ovf_d   = 1'b0;
        full_d  = 1'b0;
        last_d  = 1'b0;
        state_d = LO;
      end
      LO: begin
        if (accept) begin
          lo_d   = load_data;
          last_d = load_last;
          if (load_last) begin
            wdata_d = {8'h00, load_data};
            state_d = WRITE;
          end else begin
            state_d = HI;
          end
        end
      end
      HI: begin
        if (accept) begin
          wdata_d = {load_data, lo_q};
          last_d  = load_last;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Pointer saturates at the top word; full_q then suppresses writes.
        if (!full_q) begin
          if (ptr_q == PTR_MAX) full_d = 1'b1;
          else                  ptr_d  = ptr_q + ADDR_W'(2);
        end
        state_d = last_q ? RESTART : LO;
      end
      RESTART: state_d = RUN;
      default: state_d = RUN;
    endcase

    // Registered outputs reflect the state being entered.
    if (state_d == WRITE && full_q) ovf_d = 1'b1;
    we_d      = (state_d == WRITE) && !full_q;
    ready_d   = (state_d == LO) || (state_d == HI);
    stall_d   = (state_d != RUN);
    busy_d    = (state_d != RUN);
    restart_d = (state_d == RESTART);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      lo_q      <= '0;
      last_q    <= 1'b0;
      full_q    <= 1'b0;
      wdata_q   <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      stall_q   <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lo_q      <= lo_d;
      last_q    <= last_d;
      full_q    <= full_d;
      wdata_q   <= wdata_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      stall_q   <= stall_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_addr   = (state_q == RUN) ? fetch_addr : ptr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign load_ready = ready_q;
  assign cpu_stall  = stall_q;
  assign pc_restart = restart_q;
  assign load_busy  = busy_q;
  assign load_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl: directed self-checking bench for imem_load_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  fetch_addr;
  logic        load_req;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_last;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_stall;
  logic        pc_restart;
  logic        load_busy;
  logic        load_ovf;

  int total = 0;
  int bad   = 0;

  logic [8:0]  wa[$];
  logic [15:0] wd[$];
  logic [7:0]  img[$];
  int          rcnt;
  logic        stall_at_restart;

  imem_load_ctrl #(.ADDR_W(9), .WORD_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .load_req   (load_req),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_last  (load_last),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_stall  (cpu_stall),
    .pc_restart (pc_restart),
    .load_busy  (load_busy),
    .load_ovf   (load_ovf)
  );

  always #5 clk = ~clk;

  // Write/restart monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
      if (pc_restart) begin
        rcnt++;
        stall_at_restart = cpu_stall;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int t = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'hxx;
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_load(input string name, input int gapmode);
    int t = 0;
    int nw;
    int ne;
    logic [15:0] ew;
    logic [7:0]  hb;
    wa.delete();
    wd.delete();
    rcnt = 0;
    stall_at_restart = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check({name, "_stall_entry"}, 32'(cpu_stall), 32'd1);
    while (!load_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ovf_cleared"}, 32'(load_ovf), 32'd0);
    for (int i = 0; i < img.size(); i++)
      send_byte(img[i], (i == img.size() - 1), (gapmode != 0) ? (i % 3) : 0);
    t = 0;
    while (load_busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_end"}, 32'(load_busy), 32'd0);
    check({name, "_stall_end"}, 32'(cpu_stall), 32'd0);
    check({name, "_restarts"}, 32'(rcnt), 32'd1);
    check({name, "_stall_in_restart"}, 32'(stall_at_restart), 32'd1);
    nw = (img.size() + 1) / 2;
    ne = (nw > 256) ? 256 : nw;
    check({name, "_write_count"}, 32'(wa.size()), 32'(ne));
    check({name, "_ovf"}, 32'(load_ovf), (nw > 256) ? 32'd1 : 32'd0);
    for (int k = 0; k < ne; k++) begin
      hb = (2 * k + 1 < img.size()) ? img[2 * k + 1] : 8'h00;
      ew = {hb, img[2 * k]};
      check($sformatf("%s_addr%0d", name, k), (k < wa.size()) ? 32'(wa[k]) : 32'hdead, 32'(2 * k));
      check($sformatf("%s_data%0d", name, k), (k < wd.size()) ? 32'(wd[k]) : 32'hdead, 32'(ew));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_addr = 9'h004;
    load_req   = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    rcnt       = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_mem_addr", 32'(mem_addr), 32'h004);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_ovf", 32'(load_ovf), 32'd0);
    check("rst_restart", 32'(pc_restart), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);

    img = '{8'h34, 8'h12, 8'h78, 8'h56};
    do_load("even", 0);
    check("even_w0", (wd.size() > 0) ? 32'(wd[0]) : 32'hdead, 32'h1234);
    check("even_w1", (wd.size() > 1) ? 32'(wd[1]) : 32'hdead, 32'h5678);
    fetch_addr = 9'h010;
    #1;
    check("run_passthru", 32'(mem_addr), 32'h010);

    img = '{8'hAA, 8'hBB, 8'hCC};
    do_load("odd", 0);
    check("odd_w1", (wd.size() > 1) ? 32'(wd[1]) : 32'hdead, 32'h00CC);

    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    do_load("gaps", 1);

    img.delete();
    for (int i = 0; i < 516; i++) img.push_back(8'(i ^ (i >> 8)));
    do_load("big", 0);
    check("big_last_addr", (wa.size() == 256) ? 32'(wa[255]) : 32'hdead, 32'h1FE);
    repeat (2) @(negedge clk);
    check("big_ovf_sticky", 32'(load_ovf), 32'd1);

    img = '{8'h5A, 8'hA5};
    do_load("after_ovf", 0);

    // Reset while waiting for the high byte.
    rcnt = 0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h11, 1'b0, 0);
    check("hi_ready_before_rst", 32'(load_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(load_ready), 32'd0);
    check("arst_stall", 32'(cpu_stall), 32'd0);
    check("arst_busy", 32'(load_busy), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_restart", 32'(pc_restart), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'h010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_restart", 32'(rcnt), 32'd0);
    check("arst_run_busy", 32'(load_busy), 32'd0);
    check("arst_run_addr", 32'(mem_addr), 32'h010);

    img = '{8'hEF, 8'hBE};
    do_load("post_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the single port of the 512-byte instruction memory and shares it between the IF-stage fetch path and a byte-serial program loader.
- In RUN it passes the fetch address straight through.
- On a load request it stalls the core, assembles incoming bytes into 16-bit words, and writes them from address 0 upward. It then pulses a PC restart and returns the port to fetch.

Parameters:
- ADDR_W, 9, byte-address width of instruction memory (512 B).
- WORD_W, 16, instruction width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_addr  in  ADDR_W  byte address from IF stage (pc low bits).
- load_req  in  1  level; request to enter load mode.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte.
- load_ready  out  1  controller accepts a byte this cycle when load_valid & load_ready.
- load_last  in  1  qualifies the accepted byte as final byte of image.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_wdata  out  WORD_W  write data.
- mem_we  out  1  write strobe, one cycle per word.
- cpu_stall  out  1  freeze IF/pipeline (drives stall).
- pc_restart  out  1  one-cycle pulse forcing pc to 0.
- load_busy  out  1  high in any non-RUN state.
- load_ovf  out  1  sticky: image exceeded memory; cleared on next load entry.

Behaviour:
- All outputs registered except mem_addr, which is combinational: fetch_addr in RUN, write pointer otherwise.
- Reset values: state=RUN, load_ready=0, mem_we=0, mem_wdata=0, cpu_stall=0, pc_restart=0, load_busy=0, load_ovf=0, write pointer=0, low-byte holding reg=0.
- States: RUN, DRAIN, LO, HI, WRITE, RESTART.
- RUN:
  - load_req=1 -> DRAIN.
  - cpu_stall is registered high the same edge.
- DRAIN:
  - Exactly one cycle, so an in-flight fetch completes.
  - Clears pointer and load_ovf.
  - Goes to LO.
- LO:
  - load_ready=1.
  - On accepted byte: latch it as low byte.
  - If load_last=1, set high byte=0x00 and go to WRITE.
  - Otherwise go to HI.
- HI:
  - load_ready=1.
  - On accepted byte: form word = {byte, low byte} (little-endian) and go to WRITE.
  - Remember load_last.
- WRITE:
  - mem_we=1 for exactly one cycle; mem_addr=pointer, with pointer[0]=0 always.
  - Then pointer += 2.
  - If the last flag was seen -> RESTART, else -> LO.
  - load_ready=0 in WRITE. Throughput is therefore at most 2 bytes per 3 cycles.
- Overflow:
  - If WRITE occurs with pointer=2^ADDR_W-2, the write happens and the pointer saturates (no wrap).
  - Any subsequent WRITE before last is suppressed (mem_we=0) and sets load_ovf.
  - Bytes are still accepted so the loader drains.
- RESTART:
  - pc_restart=1 for one cycle, cpu_stall still 1.
  - Next cycle RUN with cpu_stall=0, so fetch resumes at address 0.
- load_req:
  - Sampled only in RUN.
  - Deassertion mid-load is ignored; only load_last ends a load.
  - If load_req is still high on return to RUN, a new load starts. The loader must drop it.
- load_valid without load_ready: the byte is not consumed and the loader must hold it.
- rst_n low at any time returns immediately to reset values. A partial image stays in memory, and no pc_restart is issued.
- load_busy = (state != RUN).

Test Plan:
- Reset then RUN with fetch_addr=0x004 -> mem_addr=0x004, cpu_stall=0, mem_we=0, load_ready=0.
- load_req pulse, bytes 0x34,0x12,0x78,0x56 (last on 0x56):
  - mem_we twice: addr 0x000 data 0x1234, addr 0x002 data 0x5678.
  - Then one pc_restart pulse, then cpu_stall=0.
- Odd image of 3 bytes 0xAA,0xBB,0xCC (last on 0xCC) -> writes 0xBBAA@0x000 and 0x00CC@0x002.
- Loader with gaps (load_valid toggling, held during load_ready=0):
  - No byte lost or duplicated.
  - Write count equals ceil(bytes/2).
- 516-byte image:
  - 256 writes, the last at 0x1FE.
  - Remaining 2 writes suppressed, load_ovf=1 sticky.
  - pc_restart still issued; load_ovf clears on the next load entry.
- Assert rst_n=0 in HI state -> all outputs return to reset values asynchronously, with no pc_restart pulse; RUN follows after release.
